// File: rtl/vehicle_pkg.sv
// Shared vehicle codes and classifier state encoding, also used by the
// downstream BCCBC pattern detector.
package vehicle_pkg;

  localparam logic BIKE = 1'b0;
  localparam logic CAR  = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_AXLE1  = 4'b0010,
    ST_AXLE2  = 4'b0100,
    ST_REJECT = 4'b1000
  } state_e;

endpackage

// File: rtl/axle_strobe.sv
// Axle sensor front end: 2-flop synchronizer, rising-edge detect and a
// holdoff window that debounces the strip into one clean strobe per axle.
module axle_strobe #(
  parameter int unsigned HOLDOFF = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sensor_i,
  output logic strobe_o
);

  localparam int unsigned HW = $clog2(HOLDOFF + 1);

  logic          sync1_q, sync2_q, prev_q, strobe_q;
  logic [HW-1:0] hold_q;
  logic          accept_d;

  // A rise is only taken once the previous accepted strobe's window has drained.
  always_comb begin
    accept_d = sync2_q & ~prev_q & (hold_q == '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      prev_q   <= 1'b0;
      strobe_q <= 1'b0;
      hold_q   <= '0;
    end else begin
      sync1_q  <= sensor_i;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      strobe_q <= accept_d;
      if (accept_d) begin
        hold_q <= HW'(HOLDOFF);
      end else if (hold_q != '0) begin
        hold_q <= hold_q - 1'b1;
      end
    end
  end

  assign strobe_o = strobe_q;

endmodule

// File: rtl/vehicle_classifier.sv
// Classifies two-axle vehicles as BIKE/CAR from the axle-to-axle interval;
// single-axle and 3+-axle vehicles are dropped with a reject pulse.
module vehicle_classifier
  import vehicle_pkg::*;
#(
  parameter int unsigned MAX_GAP    = 1000,
  parameter int unsigned BIKE_GAP   = 200,
  parameter int unsigned QUIET_TIME = 500,
  parameter int unsigned HOLDOFF    = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sensor_i,
  output logic valid_o,
  output logic d_o,
  output logic reject_o,
  output logic busy_o
);

  localparam int unsigned GW = $clog2(MAX_GAP + 1);
  localparam int unsigned QW = $clog2(QUIET_TIME + 1);

  state_e        state_q;
  logic [GW-1:0] gap_q, gap_lat_q, gap_d;
  logic [QW-1:0] quiet_q, quiet_d;
  logic          valid_q, d_q, reject_q, busy_q;
  logic          strobe;
  logic          cls_d;

  axle_strobe #(.HOLDOFF(HOLDOFF)) u_strobe (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .sensor_i (sensor_i),
    .strobe_o (strobe)
  );

  always_comb begin
    gap_d   = gap_q + 1'b1;
    quiet_d = quiet_q + 1'b1;
    cls_d   = (32'(gap_lat_q) < BIKE_GAP) ? BIKE : CAR;
  end

  // Timeouts fire on the edge where the incremented count would reach the
  // limit; a strobe on that same edge takes priority.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      gap_q     <= '0;
      gap_lat_q <= '0;
      quiet_q   <= '0;
      valid_q   <= 1'b0;
      d_q       <= BIKE;
      reject_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      valid_q  <= 1'b0;
      reject_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (strobe) begin
            state_q <= ST_AXLE1;
            gap_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_AXLE1: begin
          if (strobe) begin
            gap_lat_q <= gap_d;
            quiet_q   <= '0;
            state_q   <= ST_AXLE2;
          end else if (gap_q == GW'(MAX_GAP - 1)) begin
            reject_q <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= ST_IDLE;
          end else begin
            gap_q <= gap_d;
          end
        end
        ST_AXLE2: begin
          if (strobe) begin
            quiet_q <= '0;
            state_q <= ST_REJECT;
          end else if (quiet_q == QW'(QUIET_TIME - 1)) begin
            valid_q <= 1'b1;
            d_q     <= cls_d;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            quiet_q <= quiet_d;
          end
        end
        ST_REJECT: begin
          if (strobe) begin
            quiet_q <= '0;
          end else if (quiet_q == QW'(QUIET_TIME - 1)) begin
            reject_q <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= ST_IDLE;
          end else begin
            quiet_q <= quiet_d;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign valid_o  = valid_q;
  assign d_o      = d_q;
  assign reject_o = reject_q;
  assign busy_o   = busy_q;

endmodule
